// File: rtl/max_finder_buffer.sv
// max_finder_buffer
//   Captures a vector of N FP32 elements while tracking their running maximum,
//   then replays every element in arrival order alongside the vector maximum
//   so the next stage can form x_i - max.
//
// Ports
//   clk       : clock, rising edge
//   reset     : synchronous, active-high
//   in_valid  : upstream element valid
//   in_ready  : element accepted this cycle (high only while filling)
//   in_data   : FP32 element
//   out_valid : replayed element valid (high only while emitting)
//   out_ready : downstream accepts the element
//   out_data  : replayed FP32 element
//   out_max   : FP32 maximum of the vector, constant for the whole replay
//   out_last  : high with the Nth replayed element
module max_finder_buffer #(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] out_max,
    output logic        out_last
);

    localparam logic [31:0] NEG_INF = 32'hFF80_0000;
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    typedef enum logic {FILL, EMIT} state_t;

    state_t        state;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   max_reg;
    logic [31:0]   mem [N];

    // Sign-magnitude ordering on raw bits. Ties are "not greater" so the first
    // occurrence (and its exact bit pattern, e.g. -0 before +0) is kept.
    // NaNs fall out of the same bit rule; nothing special-cased.
    function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) begin
            if (a[30:0] == 31'd0 && b[30:0] == 31'd0)
                return 1'b0;
            return !a[31];
        end else if (!a[31]) begin
            return a[30:0] > b[30:0];
        end else begin
            return a[30:0] < b[30:0];
        end
    endfunction

    logic        accept;
    logic        xfer;
    logic [31:0] new_max;

    assign accept  = in_valid & in_ready;
    assign xfer    = out_valid & out_ready;
    assign new_max = gt(in_data, max_reg) ? in_data : max_reg;

    // Buffer is written only during FILL, so the combinational read below
    // stays stable while the replay is stalled.
    assign out_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_cnt] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            wr_cnt    <= '0;
            rd_ptr    <= '0;
            max_reg   <= NEG_INF;
            out_valid <= 1'b0;
            out_max   <= 32'd0;
            out_last  <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        max_reg <= new_max;
                        if (wr_cnt == LAST_IDX) begin
                            // Final max must include this Nth element.
                            state     <= EMIT;
                            wr_cnt    <= '0;
                            rd_ptr    <= '0;
                            out_max   <= new_max;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            out_last  <= 1'b0;  // N >= 2
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        if (out_last) begin
                            state     <= FILL;
                            rd_ptr    <= '0;
                            max_reg   <= NEG_INF;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            rd_ptr   <= rd_ptr + 1'b1;
                            out_last <= (rd_ptr + 1'b1) == LAST_IDX;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_max_finder_buffer.sv
module tb_max_finder_buffer;

    localparam int N = 4;

    logic        clk, reset;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        out_valid, out_ready;
    logic [31:0] out_data, out_max;
    logic        out_last;

    max_finder_buffer #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_max   (out_max),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] m;
        logic        l;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   pops  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, pops and compares each transfer.
    logic        stalled = 1'b0;
    logic [31:0] h_data, h_max;
    logic        h_last;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 1'b0;
                continue;
            end
            if (out_valid) begin
                chk("in_ready low during replay", {31'd0, in_ready}, 32'd0);
                if (stalled) begin
                    chk("held out_data", out_data, h_data);
                    chk("held out_max", out_max, h_max);
                    chk("held out_last", {31'd0, out_last}, {31'd0, h_last});
                end
                if (out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected output", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_max", out_max, e.m);
                        chk("out_last", {31'd0, out_last}, {31'd0, e.l});
                        pops++;
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    h_data  = out_data;
                    h_max   = out_max;
                    h_last  = out_last;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // Driver helpers; all start and end on a falling edge.
    task automatic push(input logic [31:0] d, input bit last);
        bit ok;
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            ok = in_ready;
            @(negedge clk);
            n++;
        end while (!ok && n < 300);
        in_valid = 1'b0;
        if (!ok)
            chk("accept timeout", 32'd0, 32'd1);
        else if (last)
            chk("out_valid after last accept", {31'd0, out_valid}, 32'd1);
        else
            chk("out_valid before last accept", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_vec(input logic [31:0] e0, e1, e2, e3, mx);
        q.push_back('{d: e0, m: mx, l: 1'b0});
        q.push_back('{d: e1, m: mx, l: 1'b0});
        q.push_back('{d: e2, m: mx, l: 1'b0});
        q.push_back('{d: e3, m: mx, l: 1'b1});
    endtask

    task automatic send_vec(input logic [31:0] e0, e1, e2, e3, mx);
        expect_vec(e0, e1, e2, e3, mx);
        push(e0, 0);
        push(e1, 0);
        push(e2, 0);
        push(e3, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() != 0)
            chk("drain timeout", 32'(q.size()), 32'd0);
        @(negedge clk);
        chk("in_ready after replay", {31'd0, in_ready}, 32'd1);
        chk("out_valid after replay", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic wait_pops(input int target);
        int n = 0;
        while (pops < target && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (pops < target)
            chk("pop wait timeout", 32'(pops), 32'(target));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_last", {31'd0, out_last}, 32'd0);
        chk("reset out_max", out_max, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: mixed-sign vector, back-to-back
        send_vec(32'h3F800000, 32'h40000000, 32'hC0400000, 32'h3F000000, 32'h40000000);
        drain();

        // 2: all negative
        send_vec(32'hBF800000, 32'hBF000000, 32'hC0800000, 32'hC0000000, 32'hBF000000);
        drain();

        // 3: backpressure for 3 cycles after the 2nd replayed element
        send_vec(32'h40400000, 32'hC1200000, 32'h41200000, 32'h3E800000, 32'h41200000);
        wait_pops(pops + 2);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // 4: input bubbles 1,0,0,1,1,0,1
        expect_vec(32'h41000000, 32'h3F800000, 32'h42000000, 32'hC2000000, 32'h42000000);
        push(32'h41000000, 0);
        idle();
        idle();
        push(32'h3F800000, 0);
        push(32'h42000000, 0);
        idle();
        push(32'hC2000000, 1);
        drain();

        // 5: signed-zero tie, then back-to-back vector proving max re-init
        send_vec(32'h80000000, 32'h00000000, 32'hBF800000, 32'hC0000000, 32'h80000000);
        send_vec(32'h7F800000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h7F800000);
        drain();

        // 6: reset one cycle after the 2nd replay transfer
        send_vec(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40800000);
        wait_pops(pops + 2);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        @(negedge clk);
        chk("post-reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("post-reset out_max", out_max, 32'd0);
        send_vec(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
